imm_extractor: RTL and testbench

RV32I immediate-extraction stage for the processor datapath. Takes a 32-bit instruction word and an immediate-format selector, reassembles the scattered immediate bit fields into a 32-bit operand, and registers it for the execute stage. Sign or zero extension depends on the format. Sits between instruction decode and the ALU/branch-target operand muxes.

---
 rtl/imm_extractor.sv | 79 +++++++
 tb/tb_imm_extractor.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/imm_extractor.sv
// imm_extractor
//
// RV32I immediate-extraction stage. It takes a 32-bit instruction word and
// an immediate-format selector, puts the scattered immediate fields back
// together into a 32-bit operand, and registers that operand for the
// execute stage. The format decides whether the result is sign- or
// zero-extended.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   in_valid   in/imm_type carry a real instruction this cycle
//   in         32-bit instruction word
//   imm_type   format selector:
//                000 I, 001 B, 010 S, 011 U, 100 J, 101 SHAMT, 110 ZIMM, 111 NONE
//   out        extracted, extended immediate (registered)
//   out_valid  out was captured from a valid input on the last edge

module imm_extractor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in,
  input  logic [2:0]  imm_type,
  output logic [31:0] out,
  output logic        out_valid
);

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_B     = 3'b001;
  localparam logic [2:0] IMM_S     = 3'b010;
  localparam logic [2:0] IMM_U     = 3'b011;
  localparam logic [2:0] IMM_J     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;
  localparam logic [2:0] IMM_ZIMM  = 3'b110;
  localparam logic [2:0] IMM_NONE  = 3'b111;

  logic        sign_bit;
  logic [31:0] extracted;

  assign sign_bit = in[31];

  // Reassemble the immediate for the selected format. Each branch reads only
  // the instruction bits that belong to its format. Every other bit comes from
  // a constant or from the sign bit, so unused (possibly unknown) bits of the
  // word never reach the result. The default covers NONE and also gives the
  // mux a defined value for any unknown selector.
  always_comb begin
    extracted = 32'h0000_0000;
    case (imm_type)
      IMM_I:     extracted = {{20{sign_bit}}, in[31:20]};
      IMM_B:     extracted = {{19{sign_bit}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
      IMM_S:     extracted = {{20{sign_bit}}, in[31:25], in[11:7]};
      IMM_U:     extracted = {in[31:12], 12'h000};
      IMM_J:     extracted = {{11{sign_bit}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
      IMM_SHAMT: extracted = {27'b0, in[24:20]};
      IMM_ZIMM:  extracted = {27'b0, in[19:15]};
      IMM_NONE:  extracted = 32'h0000_0000;
      default:   extracted = 32'h0000_0000;
    endcase
  end

  // Output register. Reset takes priority over in_valid, so an in-flight
  // result is dropped. out is loaded only from a valid input, which means it
  // keeps its last result through idle cycles. out_valid is a one-cycle
  // delayed copy of in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= 32'h0000_0000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= extracted;
      end
    end
  end

endmodule

// File: tb/tb_imm_extractor.sv
// tb_imm_extractor
//
// Directed bench for imm_extractor. A table of {instruction, format,
// expected immediate} records is applied back-to-back. Hand-written
// sequences then cover reset, hold-on-idle and reset arriving mid-stream.

module tb_imm_extractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in;
  logic [2:0]  imm_type;
  logic [31:0] out;
  logic        out_valid;

  int n_checks;
  int n_fails;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [31:0] expected;
  } vec_t;

  vec_t vecs[$];

  imm_extractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in        (in),
    .imm_type  (imm_type),
    .out       (out),
    .out_valid (out_valid)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, let the rising edge capture them, and return
  // 1 unit after that edge so the outputs can be sampled away from the edge.
  task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                               input logic [2:0] fmt);
    in_valid = valid;
    in       = instr;
    imm_type = fmt;
    @(posedge clk);
    #1;
  endtask

  // Compare the registered outputs against the values the bench expects.
  task automatic checkOutput(input string name, input logic [31:0] exp_out,
                             input logic exp_valid);
    n_checks++;
    if (out !== exp_out || out_valid !== exp_valid) begin
      n_fails++;
      $display("[TB] FAIL %s: out=%08h out_valid=%b, expected out=%08h out_valid=%b",
               name, out, out_valid, exp_out, exp_valid);
    end
  endtask

  // Main test sequence.
  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in       = 32'h0;
    imm_type = 3'b000;

    // Table contents. x bits mark positions the selected format must ignore.
    vecs.push_back('{"I_pos",     {12'h7FF, 20'bx},                          3'b000, 32'h0000_07FF});
    vecs.push_back('{"I_neg",     32'hFFF0_0000,                             3'b000, 32'hFFFF_FFFF});
    vecs.push_back('{"I_min",     32'h8000_0000,                             3'b000, 32'hFFFF_F800});
    vecs.push_back('{"B_pos",     32'b0011_111x_xxxx_xxxx_xxxx_0111_1xxx_xxxx, 3'b001, 32'h0000_0BEE});
    vecs.push_back('{"B_neg",     32'b1011_111x_xxxx_xxxx_xxxx_0111_1xxx_xxxx, 3'b001, 32'hFFFF_FBEE});
    vecs.push_back('{"B_bit7",    32'h0000_0080,                             3'b001, 32'h0000_0800});
    vecs.push_back('{"B_lowfld",  32'h0000_0F00,                             3'b001, 32'h0000_001E});
    vecs.push_back('{"S_ones",    32'hFE00_0F80,                             3'b010, 32'hFFFF_FFFF});
    vecs.push_back('{"S_low",     32'h0000_0F80,                             3'b010, 32'h0000_001F});
    vecs.push_back('{"S_high",    32'h7E00_0000,                             3'b010, 32'h0000_07E0});
    vecs.push_back('{"U_mix",     {20'h12345, 12'bx},                        3'b011, 32'h1234_5000});
    vecs.push_back('{"U_ones",    32'hFFFF_FFFF,                             3'b011, 32'hFFFF_F000});
    vecs.push_back('{"J_sign",    32'h8000_0000,                             3'b100, 32'hFFF0_0000});
    vecs.push_back('{"J_pos",     32'h7FFF_F000,                             3'b100, 32'h000F_FFFE});
    vecs.push_back('{"J_bit20",   32'h0010_0000,                             3'b100, 32'h0000_0800});
    vecs.push_back('{"J_bit12",   32'h0000_1000,                             3'b100, 32'h0000_1000});
    vecs.push_back('{"SHAMT_ones",32'hFFFF_FFFF,                             3'b101, 32'h0000_001F});
    vecs.push_back('{"SHAMT_mix", 32'h0150_0000,                             3'b101, 32'h0000_0015});
    vecs.push_back('{"ZIMM_ones", 32'hFFFF_FFFF,                             3'b110, 32'h0000_001F});
    vecs.push_back('{"ZIMM_mix",  32'h000A_8000,                             3'b110, 32'h0000_0015});
    vecs.push_back('{"NONE_ones", 32'hFFFF_FFFF,                             3'b111, 32'h0000_0000});

    // Reset while in_valid is high: reset must win.
    rst_n = 1'b0;
    applyStimulus(1'b1, 32'hFFFF_FFFF, 3'b000);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 3'b000);
    checkOutput("reset_state", 32'h0000_0000, 1'b0);
    rst_n = 1'b1;

    // Table vectors applied back-to-back, one result per cycle, with the
    // format changing from one cycle to the next.
    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i].instr, vecs[i].fmt);
      checkOutput(vecs[i].name, vecs[i].expected, 1'b1);
    end

    // Hold: one valid pulse, then a new word with in_valid low.
    applyStimulus(1'b1, 32'h7FF0_0000, 3'b000);
    checkOutput("hold_capture", 32'h0000_07FF, 1'b1);
    applyStimulus(1'b0, 32'hFFF0_0000, 3'b000);
    checkOutput("hold_idle1", 32'h0000_07FF, 1'b0);
    applyStimulus(1'b0, 32'h1234_5678, 3'b011);
    checkOutput("hold_idle2", 32'h0000_07FF, 1'b0);

    // Short back-to-back burst after the idle gap.
    applyStimulus(1'b1, 32'h1234_5678, 3'b011);
    checkOutput("burst0", 32'h1234_5000, 1'b1);
    applyStimulus(1'b1, 32'h1234_5678, 3'b101);
    checkOutput("burst1", 32'h0000_0003, 1'b1);
    applyStimulus(1'b1, 32'h1234_5678, 3'b111);
    checkOutput("burst2", 32'h0000_0000, 1'b1);

    // Reset arrives mid-stream: the in-flight result is dropped.
    applyStimulus(1'b1, 32'hFFF0_0000, 3'b000);
    checkOutput("pre_reset", 32'hFFFF_FFFF, 1'b1);
    rst_n = 1'b0;
    applyStimulus(1'b1, 32'h7FF0_0000, 3'b000);
    checkOutput("mid_reset", 32'h0000_0000, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h8000_0000, 3'b100);
    checkOutput("post_reset_first", 32'hFFF0_0000, 1'b1);
    applyStimulus(1'b0, 32'h0, 3'b000);
    checkOutput("post_reset_idle", 32'hFFF0_0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
